// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM word/state types, the arbiter
// FSM encoding and an index-width helper for the round-robin pointer.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of an index into n requesters; never less than one bit so that a
    // single-core build still has a legal (constant-zero) pointer.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping,
// returns the first hit as a one-hot vector and as a binary index.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // First requester at or after ptr (modulo N) wins.
    always_comb begin
        logic found;
        int   c;
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves one unassigned infers a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && (c < N) && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter_rr.sv
// Shares one RAM port between CPUS cores (an I-port and a D-port each).
// D-requests beat I-requests; cores are served round-robin. A selection is
// registered and held until the RAM completes, errors, or the requester
// withdraws; an IDLE cycle always separates two grants.
module memory_arbiter_rr
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic [CPUS*DATA_W-1:0]   dload,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    output logic                     ramREN,
    output logic                     ramWEN,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate,
    output logic                     ramerr
);

    localparam int IW = idx_w(CPUS);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   gnt_cpu_q, gnt_cpu_d;
    logic            gnt_is_d_q, gnt_is_d_d;
    logic            gnt_wr_q, gnt_wr_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [CPUS-1:0] d_req;
    logic [CPUS-1:0] d_gnt, i_gnt;
    logic [IW-1:0]   d_idx, i_idx;
    logic            req_held;
    logic [IW-1:0]   ptr_after;
    ramstate_t       rs;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    // Read data goes to every port; only the port whose wait drops consumes it.
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    rr_arbiter #(.N(CPUS), .IW(IW)) u_d_arb (
        .req (d_req),
        .ptr (rr_ptr_q),
        .gnt (d_gnt),
        .idx (d_idx)
    );

    rr_arbiter #(.N(CPUS), .IW(IW)) u_i_arb (
        .req (iREN),
        .ptr (rr_ptr_q),
        .gnt (i_gnt),
        .idx (i_idx)
    );

    // Is the requester we granted still asking, and where the pointer moves on success.
    always_comb begin
        req_held  = gnt_is_d_q ? d_req[gnt_cpu_q] : iREN[gnt_cpu_q];
        ptr_after = (gnt_cpu_q == IW'(CPUS - 1)) ? '0 : gnt_cpu_q + IW'(1);
    end

    // Grant register and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gnt_cpu_q  <= '0;
            gnt_is_d_q <= 1'b0;
            gnt_wr_q   <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_is_d_q <= gnt_is_d_d;
            gnt_wr_q   <= gnt_wr_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Next state: select in IDLE (D over I), then hold until ACCESS, ERROR or withdrawal.
    always_comb begin
        state_d    = state_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_is_d_d = gnt_is_d_q;
        gnt_wr_d   = gnt_wr_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|d_gnt) begin
                    gnt_cpu_d  = d_idx;
                    gnt_is_d_d = 1'b1;
                    gnt_wr_d   = dWEN[d_idx];
                    state_d    = GRANT;
                end else if (|i_gnt) begin
                    gnt_cpu_d  = i_idx;
                    gnt_is_d_d = 1'b0;
                    gnt_wr_d   = 1'b0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (rs == ACCESS) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after;
                end else if (rs == ERROR) begin
                    // Pointer stays put so the same requester is retried first.
                    state_d = IDLE;
                end else if (!req_held) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM side and wait outputs, driven only from the registered grant.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramerr   = 1'b0;
        if (state_q == GRANT) begin
            if (gnt_is_d_q) begin
                ramaddr  = daddr[int'(gnt_cpu_q)*ADDR_W +: ADDR_W];
                ramstore = dstore[int'(gnt_cpu_q)*DATA_W +: DATA_W];
                ramWEN   = gnt_wr_q;
                ramREN   = !gnt_wr_q;
                if (rs == ACCESS) begin
                    dwait[gnt_cpu_q] = 1'b0;
                end
            end else begin
                ramaddr = iaddr[int'(gnt_cpu_q)*ADDR_W +: ADDR_W];
                ramREN  = 1'b1;
                if (rs == ACCESS) begin
                    iwait[gnt_cpu_q] = 1'b0;
                end
            end
            ramerr = (rs == ERROR);
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr with two cores. Inputs change 2 time
// units after a rising edge and outputs are checked 1 unit later.
module tb_memory_arbiter_rr;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    localparam logic [31:0] IA0 = 32'h0000_0100;
    localparam logic [31:0] IA1 = 32'h0000_0104;
    localparam logic [31:0] DA0 = 32'h0000_0200;
    localparam logic [31:0] DA1 = 32'h0000_0204;
    localparam logic [31:0] DS0 = 32'hAAAA_0000;
    localparam logic [31:0] DS1 = 32'hBBBB_1111;
    localparam logic [31:0] RL  = 32'hCAFE_F00D;

    logic                 CLK;
    logic                 nRST;
    logic [CPUS-1:0]      iREN, dREN, dWEN;
    logic [CPUS*AW-1:0]   iaddr, daddr;
    logic [CPUS*DW-1:0]   dstore;
    logic [CPUS-1:0]      iwait, dwait;
    logic [CPUS*DW-1:0]   iload, dload;
    logic [AW-1:0]        ramaddr;
    logic [DW-1:0]        ramstore;
    logic                 ramREN, ramWEN, ramerr;
    logic [DW-1:0]        ramload;
    logic [1:0]           ramstate;

    int total = 0;
    int bad   = 0;

    memory_arbiter_rr #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ramerr   (ramerr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        step();
        nRST     = 1'b0;
        iREN     = '0;
        dREN     = '0;
        dWEN     = '0;
        ramstate = FREE;
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = '0;
        dREN     = '0;
        dWEN     = '0;
        iaddr    = {IA1, IA0};
        daddr    = {DA1, DA0};
        dstore   = {DS1, DS0};
        ramload  = RL;
        ramstate = FREE;

        // 1. reset values, then idle with no requests
        #3;
        chk("rst_iwait",    iwait,    2'b11);
        chk("rst_dwait",    dwait,    2'b11);
        chk("rst_ramREN",   ramREN,   1'b0);
        chk("rst_ramWEN",   ramWEN,   1'b0);
        chk("rst_ramaddr",  ramaddr,  '0);
        chk("rst_ramstore", ramstore, '0);
        chk("rst_ramerr",   ramerr,   1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        step(); step(); #1;
        chk("idle_ramREN", ramREN, 1'b0);
        chk("idle_dwait",  dwait,  2'b11);

        // 2. CPU0 I+D together: D first, then I
        step(); iREN = 2'b01; dREN = 2'b01; ramstate = BUSY; #1;
        chk("t2_arb_ramREN", ramREN, 1'b0);
        step(); #1;
        chk("t2_d_ramREN",  ramREN,  1'b1);
        chk("t2_d_ramaddr", ramaddr, DA0);
        chk("t2_d_busy1",   dwait,   2'b11);
        step(); #1;
        chk("t2_d_busy2",   dwait,   2'b11);
        step(); ramstate = ACCESS; #1;
        chk("t2_d_done",    dwait,   2'b10);
        chk("t2_d_iwait",   iwait,   2'b11);
        chk("t2_dload",     dload,   {RL, RL});
        step(); dREN = 2'b00; ramstate = BUSY; #1;
        chk("t2_gap_ramREN", ramREN, 1'b0);
        chk("t2_gap_dwait",  dwait,  2'b11);
        step(); #1;
        chk("t2_i_ramREN",  ramREN,  1'b1);
        chk("t2_i_ramaddr", ramaddr, IA0);
        step(); ramstate = ACCESS; #1;
        chk("t2_i_done",    iwait,   2'b10);
        chk("t2_iload",     iload,   {RL, RL});
        step(); iREN = 2'b00; ramstate = FREE; #1;
        chk("t2_end_ramREN", ramREN, 1'b0);

        // 3. both cores writing continuously: grants alternate 0,1,0,1
        do_reset();
        dWEN = 2'b11; ramstate = ACCESS; #1;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk("t3_ramWEN",   ramWEN,   1'b1);
            chk("t3_ramREN",   ramREN,   1'b0);
            chk("t3_ramaddr",  ramaddr,  (k % 2 == 1) ? DA1 : DA0);
            chk("t3_ramstore", ramstore, (k % 2 == 1) ? DS1 : DS0);
            chk("t3_dwait",    dwait,    (k % 2 == 1) ? 2'b01 : 2'b10);
            step(); #1;
            chk("t3_gap_ramWEN", ramWEN, 1'b0);
        end

        // 4. ERROR during CPU1 grant: pulse, no completion, CPU1 retried first
        do_reset();
        dREN = 2'b01; ramstate = ACCESS; #1;
        step(); #1;
        chk("t4_c0_done", dwait, 2'b10);
        step(); dREN = 2'b11; ramstate = BUSY; #1;
        step(); #1;
        chk("t4_c1_ramaddr", ramaddr, DA1);
        step(); ramstate = ERROR; #1;
        chk("t4_ramerr",     ramerr,  1'b1);
        chk("t4_err_dwait",  dwait,   2'b11);
        step(); ramstate = BUSY; #1;
        chk("t4_ramerr_off", ramerr,  1'b0);
        chk("t4_gap_ramREN", ramREN,  1'b0);
        step(); #1;
        chk("t4_retry_addr", ramaddr, DA1);
        step(); ramstate = ACCESS; #1;
        chk("t4_retry_done", dwait,   2'b01);
        step(); dREN = 2'b00; ramstate = FREE; #1;

        // 5. CPU0 withdraws its I-request mid-grant; pending CPU1 is served
        do_reset();
        iREN = 2'b11; ramstate = BUSY; #1;
        step(); #1;
        chk("t5_c0_ramaddr", ramaddr, IA0);
        step(); iREN = 2'b10; #1;
        chk("t5_held_ramREN", ramREN, 1'b1);
        step(); #1;
        chk("t5_abort_ramREN", ramREN, 1'b0);
        chk("t5_abort_iwait",  iwait,  2'b11);
        step(); #1;
        chk("t5_c1_ramaddr", ramaddr, IA1);
        chk("t5_c1_ramREN",  ramREN,  1'b1);
        step(); ramstate = ACCESS; #1;
        chk("t5_c1_done",    iwait,   2'b01);

        // 5b. after an abort the pointer has not moved: CPU0 still goes first
        do_reset();
        iREN = 2'b01; ramstate = BUSY; #1;
        step(); iREN = 2'b00; #1;
        step(); iREN = 2'b11; #1;
        chk("t5b_idle_ramREN", ramREN, 1'b0);
        step(); #1;
        chk("t5b_ptr_kept", ramaddr, IA0);

        // 6. asynchronous reset during a grant
        do_reset();
        dWEN = 2'b01; ramstate = BUSY; #1;
        step(); #1;
        chk("t6_gnt_ramWEN",   ramWEN,   1'b1);
        chk("t6_gnt_ramstore", ramstore, DS0);
        nRST = 1'b0; #1;
        chk("t6_rst_ramWEN",   ramWEN,   1'b0);
        chk("t6_rst_ramaddr",  ramaddr,  '0);
        chk("t6_rst_ramstore", ramstore, '0);
        chk("t6_rst_dwait",    dwait,    2'b11);
        nRST = 1'b1; dWEN = 2'b00; ramstate = FREE;
        step(); #1;
        chk("t6_post_ramWEN", ramWEN, 1'b0);
        chk("t6_post_dwait",  dwait,  2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
